// File: rtl/jtbubl_rom_slot_pkg.sv
// Shared types for the graphics ROM slot: fetch FSM encoding and burst length.
// A slot turns one 32-bit client read into one SDRAM read of BEAT_CNT 16-bit beats.
// Nothing here holds state; it only carries types and constants.
package jtbubl_pkg;

   // Fetch sequencer states: wait for a miss, request, then collect two beats
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_BEAT0 = 2'd2,
      ST_BEAT1 = 2'd3
   } slot_state_e;

   // 16-bit beats per 32-bit client word
   localparam int unsigned BEAT_CNT = 2;

endpackage

// File: rtl/jtbubl_rom_slot_if.sv
// Bus bundles around a ROM slot: the graphics client side and the SDRAM port side.
// The client bus is mastered by the fetcher; the SDRAM bus is mastered by the slot.
// No logic lives here, only signal grouping and direction.
interface jtbubl_rom_if #(
   parameter int AW = 18
);
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic          rom_ok;

   modport master (output rom_cs, rom_addr, input  rom_data, rom_ok);
   modport slave  (input  rom_cs, rom_addr, output rom_data, rom_ok);
endinterface

interface jtbubl_sdram_if #(
   parameter int SDW = 22
);
   logic           sdram_req;
   logic [SDW-1:0] sdram_addr;
   logic           sdram_ack;
   logic           data_dst;
   logic [15:0]    data_read;

   modport master (output sdram_req, sdram_addr, input  sdram_ack, data_dst, data_read);
   modport slave  (input  sdram_req, sdram_addr, output sdram_ack, data_dst, data_read);
endinterface

// File: rtl/jtbubl_rom_slot.sv
// Single-client SDRAM read responder with a one-entry 32-bit cache.
// Latency: hit is combinational (same cycle); miss completes one cycle after the second beat.
// Backpressure: sdram_req holds until ack; in-flight fetches always finish; downloading blocks and invalidates.
module jtbubl_rom_slot
   import jtbubl_pkg::*;
#(
   parameter int             AW     = 18,
   parameter int             SDW    = 22,
   parameter logic [SDW-1:0] OFFSET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              downloading,
   jtbubl_rom_if.slave       rom_bus,
   jtbubl_sdram_if.master    sdram_bus
);

   slot_state_e    state_q;
   logic           req_q;
   logic [SDW-1:0] addr_q;
   logic [AW-2:0]  ftag_q;

   logic [AW-2:0]  tag_q,   tag_d;
   logic           valid_q, valid_d;
   logic [31:0]    data_q,  data_d;

   logic           hit;
   logic           start;
   logic [SDW-1:0] fetch_addr;
   logic           unused_addr_lsb;

   // Client address bit 0 selects a half-word inside the cached 32-bit word and is not needed
   assign unused_addr_lsb = rom_bus.rom_addr[0];

   assign hit        = valid_q && (tag_q == rom_bus.rom_addr[AW-1:1]);
   assign start      = rom_bus.rom_cs && !downloading && !hit;
   assign fetch_addr = OFFSET + SDW'({rom_bus.rom_addr[AW-1:1], 1'b0});

   assign rom_bus.rom_ok        = rom_bus.rom_cs && hit && !downloading;
   assign rom_bus.rom_data      = data_q;
   assign sdram_bus.sdram_req   = req_q;
   assign sdram_bus.sdram_addr  = addr_q;

   // Cache next state: invalidate on a new fetch or download, fill as beats arrive
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) valid_d = 1'b0;
         end
         ST_BEAT0: begin
            if (sdram_bus.data_dst) data_d[15:0] = sdram_bus.data_read;
         end
         ST_BEAT1: begin
            if (sdram_bus.data_dst) begin
               data_d[31:16] = sdram_bus.data_read;
               tag_d         = ftag_q;
               valid_d       = 1'b1;
            end
         end
         default: ;
      endcase
      // A beat landing during a download is kept out of the cache
      if (downloading) valid_d = 1'b0;
   end

   // Cache registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         tag_q   <= tag_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Fetch sequencer with registered request/address; a started fetch is never aborted once acked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         addr_q  <= OFFSET;
         ftag_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= fetch_addr;
                  ftag_q  <= rom_bus.rom_addr[AW-1:1];
                  req_q   <= 1'b1;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               // The downloader owns the controller, so an unacked request is withdrawn
               if (downloading) begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (sdram_bus.sdram_ack) begin
                  req_q   <= 1'b0;
                  state_q <= ST_BEAT0;
               end
            end
            ST_BEAT0: begin
               if (sdram_bus.data_dst) state_q <= ST_BEAT1;
            end
            ST_BEAT1: begin
               if (sdram_bus.data_dst) state_q <= ST_IDLE;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Bench for jtbubl_rom_slot: directed cycle-exact scenarios then a randomized run
// against a transaction-level cache/controller model.
module tb_jtbubl_rom_slot;
   import jtbubl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic downloading;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   jtbubl_rom_if   #(.AW(18))  rb ();
   jtbubl_sdram_if #(.SDW(22)) sb ();

   jtbubl_rom_slot #(.AW(18), .SDW(22), .OFFSET(22'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .rom_bus     (rb.slave),
      .sdram_bus   (sb.master)
   );

   // Advance one cycle; inputs are applied 1ns after the edge, outputs sampled 1ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic [17:0] addr, input logic ack,
                        input logic dst, input logic [15:0] rd);
      rb.rom_cs    = cs;
      rb.rom_addr  = addr;
      sb.sdram_ack = ack;
      sb.data_dst  = dst;
      sb.data_read = rd;
   endtask

   // Synthetic SDRAM contents
   function automatic logic [15:0] mem(input logic [21:0] a);
      logic [31:0] p;
      p = {10'd0, a} * 32'h0000_9E37 + 32'h0000_1234;
      return p[15:0] ^ p[31:16];
   endfunction

   task automatic test_reset();
      rst = 1'b1; downloading = 1'b0;
      drive(1'b0, 18'h0, 1'b0, 1'b0, 16'h0);
      step(); step();
      drive(1'b1, 18'h0, 1'b0, 1'b0, 16'h0);
      #1;
      total++; if (sb.sdram_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", sb.sdram_req); end
      total++; if (sb.sdram_addr !== 22'h0) begin bad++; $display("FAIL rst_addr: got %h want 000000", sb.sdram_addr); end
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL rst_ok: got %b want 0", rb.rom_ok); end
      total++; if (rb.rom_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 00000000", rb.rom_data); end
      drive(1'b0, 18'h0, 1'b0, 1'b0, 16'h0);
      step();
      rst = 1'b0;
   endtask

   task automatic test_miss_fill();
      step(); drive(1'b1, 18'h00124, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL miss_c0_ok: got %b want 0", rb.rom_ok); end
      step(); #1;
      total++; if (sb.sdram_req !== 1'b1) begin bad++; $display("FAIL miss_c1_req: got %b want 1", sb.sdram_req); end
      total++; if (sb.sdram_addr !== 22'h000124) begin bad++; $display("FAIL miss_addr: got %h want 000124", sb.sdram_addr); end
      step(); #1;
      total++; if (sb.sdram_req !== 1'b1) begin bad++; $display("FAIL miss_c2_req_hold: got %b want 1", sb.sdram_req); end
      step(); drive(1'b1, 18'h00124, 1'b1, 1'b0, 16'h0); #1;
      step(); drive(1'b1, 18'h00124, 1'b0, 1'b1, 16'h3412); #1;
      total++; if (sb.sdram_req !== 1'b0) begin bad++; $display("FAIL miss_req_after_ack: got %b want 0", sb.sdram_req); end
      step(); drive(1'b1, 18'h00124, 1'b0, 1'b1, 16'h7856); #1;
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL miss_ok_early: got %b want 0", rb.rom_ok); end
      step(); drive(1'b1, 18'h00124, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b1) begin bad++; $display("FAIL miss_ok_fill: got %b want 1", rb.rom_ok); end
      total++; if (rb.rom_data !== 32'h7856_3412) begin bad++; $display("FAIL miss_data: got %h want 78563412", rb.rom_data); end
   endtask

   task automatic test_hit();
      logic [17:0] addrs [4];
      addrs = '{18'h00124, 18'h00125, 18'h00124, 18'h00125};
      foreach (addrs[i]) begin
         step(); drive(1'b1, addrs[i], 1'b0, 1'b0, 16'h0); #1;
         total++; if (rb.rom_ok !== 1'b1) begin bad++; $display("FAIL hit_ok[%0d]: got %b want 1", i, rb.rom_ok); end
         total++; if (rb.rom_data !== 32'h7856_3412) begin bad++; $display("FAIL hit_data[%0d]: got %h want 78563412", i, rb.rom_data); end
         total++; if (sb.sdram_req !== 1'b0) begin bad++; $display("FAIL hit_noreq[%0d]: got %b want 0", i, sb.sdram_req); end
      end
      step(); drive(1'b0, 18'h00124, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL hit_nocs: got %b want 0", rb.rom_ok); end
   endtask

   task automatic test_addr_change();
      step(); drive(1'b1, 18'h00200, 1'b0, 1'b0, 16'h0); #1;
      step(); drive(1'b1, 18'h00200, 1'b1, 1'b0, 16'h0); #1;
      total++; if (sb.sdram_addr !== 22'h000200) begin bad++; $display("FAIL chg_addr1: got %h want 000200", sb.sdram_addr); end
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b1, 16'hAAA0); #1;
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b1, 16'hBBB1); #1;
      step(); drive(1'b1, 18'h00200, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b1) begin bad++; $display("FAIL chg_tag200_ok: got %b want 1", rb.rom_ok); end
      total++; if (rb.rom_data !== 32'hBBB1_AAA0) begin bad++; $display("FAIL chg_tag200_data: got %h want bbb1aaa0", rb.rom_data); end
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL chg_300_miss: got %b want 0", rb.rom_ok); end
      step(); drive(1'b1, 18'h00300, 1'b1, 1'b0, 16'h0); #1;
      total++; if (sb.sdram_req !== 1'b1) begin bad++; $display("FAIL chg_req2: got %b want 1", sb.sdram_req); end
      total++; if (sb.sdram_addr !== 22'h000300) begin bad++; $display("FAIL chg_addr2: got %h want 000300", sb.sdram_addr); end
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b1, 16'hCCC0); #1;
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b1, 16'hDDD1); #1;
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL chg_ok_early: got %b want 0", rb.rom_ok); end
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b1) begin bad++; $display("FAIL chg_ok2: got %b want 1", rb.rom_ok); end
      total++; if (rb.rom_data !== 32'hDDD1_CCC0) begin bad++; $display("FAIL chg_data2: got %h want ddd1ccc0", rb.rom_data); end
   endtask

   task automatic test_download();
      step(); drive(1'b1, 18'h00400, 1'b0, 1'b0, 16'h0); #1;
      step(); downloading = 1'b1; #1;
      total++; if (sb.sdram_req !== 1'b1) begin bad++; $display("FAIL dl_req_before: got %b want 1", sb.sdram_req); end
      step(); downloading = 1'b0; drive(1'b1, 18'h00300, 1'b0, 1'b0, 16'h0); #1;
      total++; if (sb.sdram_req !== 1'b0) begin bad++; $display("FAIL dl_req_drop: got %b want 0", sb.sdram_req); end
      total++; if (rb.rom_ok !== 1'b0) begin bad++; $display("FAIL dl_invalid: got %b want 0", rb.rom_ok); end
      step(); drive(1'b1, 18'h00300, 1'b1, 1'b0, 16'h0); #1;
      total++; if (sb.sdram_req !== 1'b1) begin bad++; $display("FAIL dl_refetch_req: got %b want 1", sb.sdram_req); end
      total++; if (sb.sdram_addr !== 22'h000300) begin bad++; $display("FAIL dl_refetch_addr: got %h want 000300", sb.sdram_addr); end
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b1, 16'hEEE0); #1;
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b1, 16'hFFF1); #1;
      step(); drive(1'b1, 18'h00300, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b1 || rb.rom_data !== 32'hFFF1_EEE0) begin
         bad++; $display("FAIL dl_refill: got ok=%b data=%h want ok=1 data=fff1eee0", rb.rom_ok, rb.rom_data);
      end
   endtask

   task automatic test_reset_mid_fetch();
      step(); drive(1'b1, 18'h00500, 1'b0, 1'b0, 16'h0); #1;
      step(); drive(1'b1, 18'h00500, 1'b1, 1'b0, 16'h0); #1;
      step(); drive(1'b1, 18'h00500, 1'b0, 1'b1, 16'h1111); #1;
      step(); drive(1'b1, 18'h00500, 1'b0, 1'b1, 16'h2222); #1;
      rst = 1'b1; #1;
      total++; if (sb.sdram_req !== 1'b0 || sb.sdram_addr !== 22'h0) begin
         bad++; $display("FAIL rstmid_sdram: got req=%b addr=%h want req=0 addr=000000", sb.sdram_req, sb.sdram_addr);
      end
      total++; if (rb.rom_ok !== 1'b0 || rb.rom_data !== 32'h0) begin
         bad++; $display("FAIL rstmid_rom: got ok=%b data=%h want ok=0 data=00000000", rb.rom_ok, rb.rom_data);
      end
      step(); rst = 1'b0; drive(1'b0, 18'h00500, 1'b0, 1'b1, 16'h3333); #1;
      step(); drive(1'b1, 18'h00500, 1'b0, 1'b0, 16'h0); #1;
      total++; if (rb.rom_ok !== 1'b0 || rb.rom_data !== 32'h0) begin
         bad++; $display("FAIL rstmid_stray: got ok=%b data=%h want ok=0 data=00000000", rb.rom_ok, rb.rom_data);
      end
      total++; if (sb.sdram_req !== 1'b0) begin bad++; $display("FAIL rstmid_noreq: got %b want 0", sb.sdram_req); end
   endtask

   // Randomized traffic against a transaction-level model of the cache and an SDRAM controller
   task automatic test_random();
      logic [17:0] cand [6];
      logic        m_valid, pend, cs, dl, ack, dst, exp_ok;
      logic [16:0] m_tag, served;
      logic [17:0] addr;
      logic [15:0] rd;
      int          beats_left, ack_wait;
      cand = '{18'h00010, 18'h00012, 18'h01000, 18'h3FFFE, 18'h00000, 18'h20004};
      rst = 1'b1; downloading = 1'b0;
      drive(1'b0, 18'h0, 1'b0, 1'b0, 16'h0);
      step(); rst = 1'b0;
      m_valid = 1'b0; m_tag = '0; pend = 1'b0; served = '0; beats_left = 0; ack_wait = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         step();
         cs   = ($urandom % 8) != 0;
         addr = cand[$urandom % 6] | 18'($urandom % 2);
         dl   = ($urandom % 25) == 0;
         ack  = 1'b0; dst = 1'b0; rd = 16'h0;
         if (pend && !dl) begin
            if (ack_wait == 0) ack = 1'b1;
            else ack_wait--;
         end else if (beats_left > 0) begin
            dst = ($urandom % 2) == 1;
            rd  = mem(22'({served, 1'b0}) + 22'(2 - beats_left));
         end
         downloading = dl;
         drive(cs, addr, ack, dst, rd);
         #1;
         exp_ok = cs && m_valid && (m_tag == addr[17:1]) && !dl;
         total++; if (rb.rom_ok !== exp_ok) begin bad++; $display("FAIL rnd_ok@%0d: got %b want %b", cyc, rb.rom_ok, exp_ok); end
         if (exp_ok) begin
            total++;
            if (rb.rom_data !== {mem(22'({m_tag, 1'b1})), mem(22'({m_tag, 1'b0}))}) begin
               bad++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, rb.rom_data,
                               {mem(22'({m_tag, 1'b1})), mem(22'({m_tag, 1'b0}))});
            end
         end
         total++; if (sb.sdram_req !== pend) begin bad++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, sb.sdram_req, pend); end
         if (pend) begin
            total++;
            if (sb.sdram_addr !== 22'({served, 1'b0})) begin
               bad++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, sb.sdram_addr, 22'({served, 1'b0}));
            end
         end
         if (pend) begin
            if (dl) pend = 1'b0;
            else if (ack) begin pend = 1'b0; beats_left = 2; end
         end else if (beats_left > 0) begin
            if (dst) begin
               beats_left--;
               if (beats_left == 0 && !dl) begin m_valid = 1'b1; m_tag = served; end
            end
         end else if (cs && !dl && !(m_valid && m_tag == addr[17:1])) begin
            pend = 1'b1; served = addr[17:1]; m_valid = 1'b0; ack_wait = $urandom_range(0, 2);
         end
         if (dl) m_valid = 1'b0;
      end
      downloading = 1'b0;
      drive(1'b0, 18'h0, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      test_reset();
      test_miss_fill();
      test_hit();
      test_addr_change();
      test_download();
      test_reset_mid_fetch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
